// File: rtl/button_pkg.sv
// Shared definitions for the button gesture decoder: event codes,
// event width and FSM state encodings.
package button_pkg;

   localparam int EVT_W = 2;

   localparam logic [EVT_W-1:0] EVT_NONE   = 2'b00;
   localparam logic [EVT_W-1:0] EVT_SINGLE = 2'b01;
   localparam logic [EVT_W-1:0] EVT_DOUBLE = 2'b10;
   localparam logic [EVT_W-1:0] EVT_TRIPLE = 2'b11;

   // ST_WAIT2 is only reachable when TRIPLE_PRESS_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT1 = 2'd1,
      ST_WAIT2 = 2'd2
   } state_e;

endpackage

// File: rtl/button_gesture_decoder_if.sv
// Valid/ready event channel from the gesture decoder to its consumer.
// The decoder drives through the master modport, the consumer uses slave.
interface button_gesture_decoder_if;

   logic                           evt_valid;
   logic [button_pkg::EVT_W-1:0]   evt_code;
   logic                           evt_ready;

   modport master (output evt_valid, output evt_code, input  evt_ready);
   modport slave  (input  evt_valid, input  evt_code, output evt_ready);

endinterface

// File: rtl/btn_evt_fifo.sv
// Two-entry event FIFO with strict ordering. A push into a full queue
// is accepted only if a pop happens on the same edge; otherwise the
// new event is dropped and 'drop' is raised for that cycle.
module btn_evt_fifo
   import button_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [EVT_W-1:0] push_data,
   input  logic             pop,
   output logic [EVT_W-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   logic [EVT_W-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             pop_ok;
   logic             push_ok;

   // Occupancy flags, accept/drop decisions and next pointer/count values.
   always_comb begin
      full     = (count_q == 2'd2);
      empty    = (count_q == 2'd0);
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      drop     = push & full & ~pop_ok;
      wr_ptr_d = wr_ptr_q ^ push_ok;
      rd_ptr_d = rd_ptr_q ^ pop_ok;
      count_d  = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      // Stale storage is never exposed: the head reads as EVT_NONE when empty.
      head = empty ? EVT_NONE : mem_q[rd_ptr_q];
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Event storage write port.
   // NOTE: storage is not reset; validity comes from count_q, so reset only the control state.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns level changes on the debounced toggle
// line into SINGLE/DOUBLE(/TRIPLE) events grouped by a time window and
// queues them in a 2-entry FIFO toward the consumer.
// Optional feature macro: TRIPLE_PRESS_EN (adds WAIT2 and TRIPLE events;
// DOUBLE is then reported only once its window expires).
module button_gesture_decoder
   import button_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int WINDOW = 20000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       b_tog,
   button_gesture_decoder_if.master   evt_if,
   output logic                       overflow
);

   if ((WINDOW < 2) || (longint'(WINDOW) >= (longint'(1) << CNT_W))) begin : g_bad_window
      $error("button_gesture_decoder: WINDOW must be >= 2 and < 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             b_tog_q, b_tog_d;
   logic             primed_q, primed_d;
   logic             press;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire;
   logic             push;
   logic [EVT_W-1:0] push_code;
   logic             pop;
   logic [EVT_W-1:0] head;
   logic             full;
   logic             empty;
   logic             drop;
   logic             overflow_q, overflow_d;

   // Edge detection: any level change is a press once the line has been
   // sampled at least once after reset, so a level held across reset is ignored.
   always_comb begin
      b_tog_d  = b_tog;
      primed_d = 1'b1;
      press    = primed_q & (b_tog ^ b_tog_q);
   end

   // Gesture FSM and window counter. cnt_q holds the number of edges since
   // the arming press, so the window expires on edge t+WINDOW.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_code = EVT_NONE;
      expire    = (state_q != ST_IDLE) && (cnt_q == WIN_END);
      if (state_q != ST_IDLE) begin
         cnt_d = cnt_q + CNT_ONE;
      end
      case (state_q)
         ST_IDLE: begin
            if (press) begin
               state_d = ST_WAIT1;
               cnt_d   = CNT_ONE;
            end
         end
         ST_WAIT1: begin
            if (expire) begin
               push      = 1'b1;
               push_code = EVT_SINGLE;
               // A press on the expiry edge starts the next gesture.
               state_d   = press ? ST_WAIT1 : ST_IDLE;
               cnt_d     = press ? CNT_ONE : '0;
            end else if (press) begin
`ifdef TRIPLE_PRESS_EN
               state_d = ST_WAIT2;
               cnt_d   = CNT_ONE;
`else
               push      = 1'b1;
               push_code = EVT_DOUBLE;
               state_d   = ST_IDLE;
               cnt_d     = '0;
`endif
            end
         end
`ifdef TRIPLE_PRESS_EN
         ST_WAIT2: begin
            if (expire) begin
               push      = 1'b1;
               push_code = EVT_DOUBLE;
               state_d   = press ? ST_WAIT1 : ST_IDLE;
               cnt_d     = press ? CNT_ONE : '0;
            end else if (press) begin
               push      = 1'b1;
               push_code = EVT_TRIPLE;
               state_d   = ST_IDLE;
               cnt_d     = '0;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Overflow pulse follows the dropped push by one edge, like the events.
   always_comb begin
      overflow_d = drop;
   end

   // State registers for edge detect, FSM, window counter and overflow pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_tog_q    <= 1'b0;
         primed_q   <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         b_tog_q    <= b_tog_d;
         primed_q   <= primed_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   btn_evt_fifo u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_code),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .drop      (drop)
   );

   assign pop              = ~empty & evt_if.evt_ready;
   assign evt_if.evt_valid = ~empty;
   assign evt_if.evt_code  = head;
   assign overflow         = overflow_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed testbench for button_gesture_decoder with WINDOW=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, well away from the active edge.
module tb_button_gesture_decoder;

   logic clk;
   logic rst_n;
   logic b_tog;
   logic overflow;
   int   checks;
   int   failures;
   int   cyc;
   logic seen;

   button_gesture_decoder_if evt_if ();

   button_gesture_decoder #(
      .CNT_W  (16),
      .WINDOW (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .b_tog    (b_tog),
      .evt_if   (evt_if),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic go_to(input int e);
      while (cyc < e) tick();
   endtask

   task automatic tog();
      b_tog = ~b_tog;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      b_tog    = 1'b0;
      evt_if.evt_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",    {3'b0, evt_if.evt_valid}, 4'h0);
      check("rst_code",     {2'b0, evt_if.evt_code},  4'h0);
      check("rst_overflow", {3'b0, overflow},         4'h0);
      rst_n = 1'b1;
      evt_if.evt_ready = 1'b1;

      // 1: single press sampled at edge 10 -> SINGLE after edge 18, popped at 19.
      cyc = 0;
      go_to(9);  tog();
      go_to(17); check("t1_valid_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(18); check("t1_valid",        {3'b0, evt_if.evt_valid}, 4'h1);
                 check("t1_code",         {2'b0, evt_if.evt_code},  4'h1);
      go_to(19); check("t1_popped",       {3'b0, evt_if.evt_valid}, 4'h0);

`ifndef TRIPLE_PRESS_EN
      // 2: presses at 10 and 13 -> DOUBLE right after 13, no SINGLE afterwards.
      cyc = 0;
      go_to(9);  tog();
      go_to(12); tog();
                 check("t2_valid_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(13); check("t2_valid",        {3'b0, evt_if.evt_valid}, 4'h1);
                 check("t2_code",         {2'b0, evt_if.evt_code},  4'h2);
      seen = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         seen = seen | evt_if.evt_valid;
      end
      check("t2_no_extra_event", {3'b0, seen}, 4'h0);

      // 3a: presses at 10 and 17 (last cycle of window) -> DOUBLE.
      cyc = 0;
      go_to(9);  tog();
      go_to(16); tog();
                 check("t3a_valid_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(17); check("t3a_code",         {2'b0, evt_if.evt_code},  4'h2);
      go_to(18); check("t3a_popped",       {3'b0, evt_if.evt_valid}, 4'h0);

      // 3b: presses at 10 and 18 (expiry edge) -> SINGLE at 18, SINGLE at 26.
      cyc = 0;
      go_to(9);  tog();
      go_to(17); tog();
      go_to(18); check("t3b_first_code",  {2'b0, evt_if.evt_code},  4'h1);
      go_to(25); check("t3b_gap",         {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(26); check("t3b_second_code", {2'b0, evt_if.evt_code},  4'h1);
      go_to(27); check("t3b_popped",      {3'b0, evt_if.evt_valid}, 4'h0);

      // 4: consumer stalled: DOUBLE, SINGLE queued, third event dropped.
      evt_if.evt_ready = 1'b0;
      cyc = 0;
      go_to(9);  tog();
      go_to(11); tog();
      go_to(13); check("t4_head_double", {2'b0, evt_if.evt_code}, 4'h2);
      go_to(19); tog();
      go_to(28); check("t4_head_held",   {2'b0, evt_if.evt_code}, 4'h2);
                 check("t4_valid_held",  {3'b0, evt_if.evt_valid}, 4'h1);
      go_to(29); tog();
      go_to(37); check("t4_ovf_before",  {3'b0, overflow}, 4'h0);
      go_to(38); check("t4_ovf_pulse",   {3'b0, overflow}, 4'h1);
                 check("t4_head_kept",   {2'b0, evt_if.evt_code}, 4'h2);
      go_to(39); check("t4_ovf_after",   {3'b0, overflow}, 4'h0);
      evt_if.evt_ready = 1'b1;
      go_to(40); check("t4_second_code", {2'b0, evt_if.evt_code},  4'h1);
                 check("t4_second_vld",  {3'b0, evt_if.evt_valid}, 4'h1);
      go_to(41); check("t4_drained",     {3'b0, evt_if.evt_valid}, 4'h0);
`else
      // 6a: presses at 10, 12, 14 -> TRIPLE right after 14.
      cyc = 0;
      go_to(9);  tog();
      go_to(11); tog();
      go_to(13); tog();
                 check("t6a_valid_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(14); check("t6a_code",         {2'b0, evt_if.evt_code},  4'h3);
      go_to(15); check("t6a_popped",       {3'b0, evt_if.evt_valid}, 4'h0);

      // 6b: presses at 10 and 12 -> DOUBLE after window expiry at 20.
      cyc = 0;
      go_to(9);  tog();
      go_to(11); tog();
      go_to(19); check("t6b_valid_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(20); check("t6b_code",         {2'b0, evt_if.evt_code},  4'h2);
      go_to(21); check("t6b_popped",       {3'b0, evt_if.evt_valid}, 4'h0);
`endif

      // 5: reset during WAIT1 with b_tog=1 held across release -> silence.
      b_tog = 1'b1;
      cyc = 0;
      go_to(9);  tog();
      go_to(12);
      rst_n = 1'b0;
      b_tog = 1'b1;
      go_to(15); check("t5_rst_valid", {3'b0, evt_if.evt_valid}, 4'h0);
                 check("t5_rst_code",  {2'b0, evt_if.evt_code},  4'h0);
      rst_n = 1'b1;
      cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | evt_if.evt_valid | overflow;
      end
      check("t5_silent", {3'b0, seen}, 4'h0);
      // A genuine press after release still works.
      tog();
      go_to(28); check("t5_post_before", {3'b0, evt_if.evt_valid}, 4'h0);
      go_to(29); check("t5_post_code",   {2'b0, evt_if.evt_code},  4'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
